// File: rtl/bta_operand_sequencer.sv
// rtl/bta_operand_sequencer.sv - serial operand loader and result capture for the 8-operand tree adder
module bta_operand_sequencer #(
    parameter int N   = 32,
    parameter int m   = 16,
    parameter int W   = m * (N / 8),
    parameter int SW  = m + $clog2(N),
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_c0,
    input  logic          in_last,
    output logic [W-1:0]  op_a,
    output logic [W-1:0]  op_b,
    output logic [W-1:0]  op_c,
    output logic [W-1:0]  op_d,
    output logic [W-1:0]  op_e,
    output logic [W-1:0]  op_f,
    output logic [W-1:0]  op_g,
    output logic [W-1:0]  op_h,
    output logic          op_c0,
    input  logic [SW-1:0] sum_in,
    input  logic          carry_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_sum,
    output logic          out_carry
);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_WAIT   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    // Last wait count before the adder output is valid (LAT is limited to 1..15).
    localparam logic [3:0] WCNT_LAST = 4'(LAT - 1);

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic [W-1:0]  slot_q [8];
    logic [W-1:0]  slot_d [8];
    logic          c0_q, c0_d;
    logic [SW-1:0] sum_q, sum_d;
    logic          carry_q, carry_d;

    // Handshake flags and operand buses come straight from registered state.
    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_RESULT);
    assign op_a      = slot_q[0];
    assign op_b      = slot_q[1];
    assign op_c      = slot_q[2];
    assign op_d      = slot_q[3];
    assign op_e      = slot_q[4];
    assign op_f      = slot_q[5];
    assign op_g      = slot_q[6];
    assign op_h      = slot_q[7];
    assign op_c0     = c0_q;
    assign out_sum   = sum_q;
    assign out_carry = carry_q;

    // Next-state: load slots per beat, count adder latency, hold result until taken.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        slot_d  = slot_q;
        c0_d    = c0_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    slot_d[idx_q] = in_data;
                    if (idx_q == 3'd0) begin
                        c0_d = in_c0;
                    end
                    idx_d = idx_q + 3'd1;
                    // A full slot 7 closes the frame even without in_last.
                    if (in_last || (idx_q == 3'd7)) begin
                        state_d = S_WAIT;
                        wcnt_d  = 4'd0;
                    end
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + 4'd1;
                if (wcnt_q == WCNT_LAST) begin
                    sum_d   = sum_in;
                    carry_d = carry_in;
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                if (out_ready) begin
                    for (int i = 0; i < 8; i++) begin
                        slot_d[i] = '0;
                    end
                    c0_d    = 1'b0;
                    idx_d   = 3'd0;
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
                idx_d   = 3'd0;
            end
        endcase
    end

    // State registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            idx_q   <= 3'd0;
            wcnt_q  <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= '0;
            end
            c0_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= slot_d[i];
            end
            c0_q    <= c0_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

endmodule

// File: tb/tb_bta_operand_sequencer.sv
// tb/tb_bta_operand_sequencer.sv - scoreboard bench for bta_operand_sequencer
module tb_bta_operand_sequencer;

    localparam int W   = 64;
    localparam int SW  = 21;
    localparam int LAT = 2;

    typedef struct packed {
        logic [SW-1:0]       sum;
        logic                carry;
        logic [7:0][W-1:0]   ops;
        logic                c0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // main instance (LAT=2)
    logic          in_valid, in_c0, in_last, in_ready;
    logic [W-1:0]  in_data;
    logic [W-1:0]  op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h;
    logic          op_c0, carry_in, out_valid, out_ready, out_carry;
    logic [SW-1:0] sum_in, out_sum;
    logic          or_dir, or_rand, rand_or;
    assign out_ready = rand_or ? or_rand : or_dir;

    // latency instances (LAT=1 and LAT=15) share one input stream
    logic          x_valid, x_c0, x_last, x_oready;
    logic [W-1:0]  x_data;
    logic          x1_ready, x1_c0, x1_cin, x1_ov, x1_oc;
    logic [W-1:0]  x1_a, x1_b, x1_c, x1_d, x1_e, x1_f, x1_g, x1_h;
    logic [SW-1:0] x1_sin, x1_os;
    logic          x15_ready, x15_c0, x15_cin, x15_ov, x15_oc;
    logic [W-1:0]  x15_a, x15_b, x15_c, x15_d, x15_e, x15_f, x15_g, x15_h;
    logic [SW-1:0] x15_sin, x15_os;

    bta_operand_sequencer #(.LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_c0(in_c0), .in_last(in_last),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
        .op_e(op_e), .op_f(op_f), .op_g(op_g), .op_h(op_h), .op_c0(op_c0),
        .sum_in(sum_in), .carry_in(carry_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry)
    );

    bta_operand_sequencer #(.LAT(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x1_ready),
        .in_data(x_data), .in_c0(x_c0), .in_last(x_last),
        .op_a(x1_a), .op_b(x1_b), .op_c(x1_c), .op_d(x1_d),
        .op_e(x1_e), .op_f(x1_f), .op_g(x1_g), .op_h(x1_h), .op_c0(x1_c0),
        .sum_in(x1_sin), .carry_in(x1_cin), .out_valid(x1_ov),
        .out_ready(x_oready), .out_sum(x1_os), .out_carry(x1_oc)
    );

    bta_operand_sequencer #(.LAT(15)) dut_l15 (
        .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x15_ready),
        .in_data(x_data), .in_c0(x_c0), .in_last(x_last),
        .op_a(x15_a), .op_b(x15_b), .op_c(x15_c), .op_d(x15_d),
        .op_e(x15_e), .op_f(x15_f), .op_g(x15_g), .op_h(x15_h), .op_c0(x15_c0),
        .sum_in(x15_sin), .carry_in(x15_cin), .out_valid(x15_ov),
        .out_ready(x_oready), .out_sum(x15_os), .out_carry(x15_oc)
    );

    // Ideal adder models: combinational sum followed by LAT-1 pipeline registers
    function automatic logic [67:0] add8(input logic [W-1:0] a, b, c, d, e, f, g, h, input logic ci);
        return 68'(a) + 68'(b) + 68'(c) + 68'(d) + 68'(e) + 68'(f) + 68'(g) + 68'(h) + 68'(ci);
    endfunction

    logic [67:0] m_full, m_pipe, x1_full, x15_full;
    logic [67:0] x15_pipe [14];
    always_comb m_full   = add8(op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h, op_c0);
    always_comb x1_full  = add8(x1_a, x1_b, x1_c, x1_d, x1_e, x1_f, x1_g, x1_h, x1_c0);
    always_comb x15_full = add8(x15_a, x15_b, x15_c, x15_d, x15_e, x15_f, x15_g, x15_h, x15_c0);
    always @(posedge clk) begin
        m_pipe <= m_full;
        x15_pipe[0] <= x15_full;
        for (int k = 1; k < 14; k++) x15_pipe[k] <= x15_pipe[k-1];
    end
    assign sum_in   = m_pipe[SW-1:0];
    assign carry_in = m_pipe[SW];
    assign x1_sin   = x1_full[SW-1:0];
    assign x1_cin   = x1_full[SW];
    assign x15_sin  = x15_pipe[13][SW-1:0];
    assign x15_cin  = x15_pipe[13][SW];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   t_close = 0;
    int   hs_count = 0;
    int   beats_sent = 0;
    bit   in_flight = 0;
    logic ov_prev = 1'b0;
    logic [W-1:0] fv [8];
    exp_t sbq [$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) or_rand <= 1'($urandom_range(0, 1));

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Monitor: pops the scoreboard on each result handoff and checks holds/latency
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (in_valid && in_ready) hs_count++;
            if (in_flight) chk("in_ready_low_while_busy", 68'(in_ready), 68'd0);
            if (!in_ready && sbq.size() > 0) begin
                e = sbq[0];
                chk("bus_hold", {op_h[3:0], op_g[3:0], op_f[3:0], op_e[3:0], op_d[3:0], op_c[3:0], op_b[3:0], op_a[3:0], op_c0},
                    {e.ops[7][3:0], e.ops[6][3:0], e.ops[5][3:0], e.ops[4][3:0], e.ops[3][3:0], e.ops[2][3:0], e.ops[1][3:0], e.ops[0][3:0], e.c0});
            end
            if (out_valid && !ov_prev) chk("result_latency", 68'(cyc - t_close), 68'(LAT));
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    timeout_fail("unexpected_result");
                end else begin
                    e = sbq.pop_front();
                    chk("out_sum", 68'(out_sum), 68'(e.sum));
                    chk("out_carry", 68'(out_carry), 68'(e.carry));
                    chk("op_a_full", 68'(op_a), 68'(e.ops[0]));
                    chk("op_h_full", 68'(op_h), 68'(e.ops[7]));
                end
                in_flight = 0;
            end
        end
        ov_prev = out_valid;
    end

    task automatic send_beats(input int n, input bit c0, input bit last, input int gmax);
        int  g;
        int  to;
        bit  acc;
        for (int i = 0; i < n; i++) begin
            g = (gmax > 0) ? $urandom_range(0, gmax) : 0;
            repeat (g) begin
                in_valid = 1'b0;
                in_last  = 1'b1;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = fv[i];
            in_c0    = (i == 0) ? c0 : ~c0;
            in_last  = last && (i == n - 1);
            to = 0;
            do begin
                acc = in_ready;
                @(posedge clk); #1;
                to++;
            end while (!acc && to < 500);
            if (!acc) timeout_fail("beat_accept");
            beats_sent++;
            if ((last && i == n - 1) || i == 7) begin
                t_close   = cyc;
                in_flight = 1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit c0, input bit last, input int gmax);
        exp_t        e;
        logic [67:0] full;
        full = 68'(c0);
        for (int i = 0; i < 8; i++) begin
            e.ops[i] = (i < n) ? fv[i] : '0;
            full     = full + 68'(e.ops[i]);
        end
        e.sum   = full[SW-1:0];
        e.carry = full[SW];
        e.c0    = c0;
        sbq.push_back(e);
        send_beats(n, c0, last, gmax);
    endtask

    task automatic wait_idle();
        int to = 0;
        while (sbq.size() > 0 && to < 3000) begin
            @(posedge clk);
            to++;
        end
        #1;
        if (sbq.size() > 0) timeout_fail("wait_result");
    endtask

    initial begin
        int  n;
        int  l1, l15;
        bit  last;
        rst_n = 1'b0; in_valid = 0; in_data = '0; in_c0 = 0; in_last = 0;
        or_dir = 1; rand_or = 0;
        x_valid = 0; x_data = '0; x_c0 = 0; x_last = 0; x_oready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 68'(in_ready), 68'd1);
        chk("rst_out_valid", 68'(out_valid), 68'd0);
        chk("rst_out_sum", {46'd0, out_carry, out_sum}, 68'd0);
        chk("rst_buses", 68'(op_a | op_b | op_c | op_d | op_e | op_f | op_g | op_h), 68'd0);
        chk("rst_op_c0", 68'(op_c0), 68'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full frame 1..8
        for (int i = 0; i < 8; i++) fv[i] = 64'(i + 1);
        send_frame(8, 0, 1, 0);
        wait_idle();

        // Short frame 5,6,7 with carry-in
        fv[0] = 64'd5; fv[1] = 64'd6; fv[2] = 64'd7;
        send_frame(3, 1, 1, 0);
        chk("short_op_a", 68'(op_a), 68'd5);
        chk("short_op_c", 68'(op_c), 68'd7);
        chk("short_op_d_h", 68'(op_d | op_e | op_f | op_g | op_h), 68'd0);
        chk("short_op_c0", 68'(op_c0), 68'd1);
        wait_idle();

        // Stalled result with in_valid pulses
        or_dir = 0;
        fv[0] = 64'd10; fv[1] = 64'd20; fv[2] = 64'd30;
        send_frame(3, 0, 1, 0);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (!out_valid) timeout_fail("stall_out_valid");
        n = hs_count;
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            in_data  = 64'hDEAD;
            @(posedge clk); #1;
            chk("stall_out_sum", 68'(out_sum), 68'h3C);
            chk("stall_out_valid", 68'(out_valid), 68'd1);
        end
        in_valid = 0;
        chk("stall_no_beat", 68'(hs_count), 68'(n));
        or_dir = 1;
        @(posedge clk); #1;
        chk("handoff_buses_zero", 68'(op_a | op_b | op_c | op_d | op_e | op_f | op_g | op_h), 68'd0);
        chk("handoff_c0_zero", 68'(op_c0), 68'd0);
        chk("handoff_in_ready", 68'(in_ready), 68'd1);
        chk("stall_sb_empty", 68'(sbq.size()), 68'd0);

        // Reset in the middle of a frame
        for (int i = 0; i < 8; i++) fv[i] = 64'(i + 1);
        send_beats(4, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_buses", 68'(op_a | op_b | op_c | op_d), 68'd0);
        chk("midrst_c0", 68'(op_c0), 68'd0);
        chk("midrst_in_ready", 68'(in_ready), 68'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(8, 0, 1, 0);
        wait_idle();

        // Random frames with random gaps and back-pressure
        rand_or = 1;
        for (int f = 0; f < 200; f++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < 8; i++) fv[i] = {$urandom, $urandom};
            last = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            send_frame(n, 1'($urandom_range(0, 1)), last, 3);
        end
        wait_idle();
        rand_or = 0;
        @(posedge clk); #1;
        chk("beat_count", 68'(hs_count), 68'(beats_sent));

        // LAT=1 and LAT=15 instances with the 1..8 frame
        for (int i = 0; i < 8; i++) begin
            x_valid = 1; x_data = 64'(i + 1); x_last = (i == 7); x_c0 = 0;
            if (!(x1_ready && x15_ready)) timeout_fail("lat_beat_ready");
            @(posedge clk); #1;
        end
        x_valid = 0; x_last = 0;
        n = cyc; l1 = -1; l15 = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (x1_ov && l1 < 0) begin
                l1 = cyc - n;
                chk("lat1_sum", 68'(x1_os), 68'h24);
            end
            if (x15_ov && l15 < 0) begin
                l15 = cyc - n;
                chk("lat15_sum", 68'(x15_os), 68'h24);
            end
        end
        chk("lat1_latency", 68'(l1), 68'd1);
        chk("lat15_latency", 68'(l15), 68'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
